// File: rtl/cpu_types_pkg.sv
// Shared cache types: coherence states and the snoop address split.
package cpu_types_pkg;

    typedef enum logic [1:0] {
        I = 2'b00,
        S = 2'b01,
        M = 2'b10
    } cohstate_t;

    localparam int NWAYS      = 2;
    localparam int WORD_W     = 32;
    localparam int LINE_W     = 64;
    localparam int TAG_W      = 26;
    localparam int IDX_W      = 3;
    localparam int TAG_LSB    = 6;
    localparam int IDX_LSB    = 3;
    localparam int BLKOFF_BIT = 2;

endpackage

// File: rtl/snoop_tag_match.sv
// 2-way tag compare for snoop lookups; way 0 wins if both ways match.
module snoop_tag_match
    import cpu_types_pkg::*;
(
    input  logic [TAG_W-1:0]             tag,
    input  logic [NWAYS-1:0][TAG_W-1:0]  way_tag,
    input  cohstate_t [NWAYS-1:0]        way_state,
    output logic                         hit,
    output logic                         way
);

    logic [NWAYS-1:0] match;

    for (genvar w = 0; w < NWAYS; w++) begin : g_way
        assign match[w] = (way_tag[w] == tag) && (way_state[w] != I);
    end

    assign hit = |match;
    assign way = ~match[0];

endmodule

// File: rtl/snoop_responder.sv
// Snoop side of the dcache: looks up snooped lines, writes back dirty data
// and downgrades/invalidates the local copy.
module snoop_responder
    import cpu_types_pkg::*;
(
    input  logic                          CLK,
    input  logic                          nRST,
    input  logic                          ccwait,
    input  logic                          ccinv,
    input  logic [31:0]                   ccsnoopaddr,
    input  logic                          dwait,
    output logic                          cctrans,
    output logic                          ccwrite,
    output logic                          dWEN,
    output logic [31:0]                   daddr,
    output logic [WORD_W-1:0]             dstore,
    output logic [IDX_W-1:0]              snp_idx,
    input  logic [NWAYS-1:0][TAG_W-1:0]   snp_tag,
    input  cohstate_t [NWAYS-1:0]         snp_state,
    input  logic [NWAYS-1:0][LINE_W-1:0]  snp_data,
    output logic                          snp_wen,
    output logic                          snp_way,
    output cohstate_t                     snp_nstate,
    output logic                          snp_busy
);

    typedef enum logic [2:0] {
        IDLE, LOOKUP, FLUSH0, FLUSH1, INVAL, WAIT
    } snp_fsm_t;

    snp_fsm_t          state;
    logic [TAG_W-1:0]  tag_r;
    logic [IDX_W-1:0]  idx_r;
    logic              inv_r;
    logic              way_r;
    logic [LINE_W-1:0] line_r;
    logic              flushed_r;

    logic      hit, hit_way;
    cohstate_t hit_state;
    snp_fsm_t  done_state;
    logic      flushing;
    logic      unused_addr_bits;

    assign unused_addr_bits = ^ccsnoopaddr[BLKOFF_BIT:0];

    snoop_tag_match u_match (
        .tag       (tag_r),
        .way_tag   (snp_tag),
        .way_state (snp_state),
        .hit       (hit),
        .way       (hit_way)
    );

    assign hit_state = snp_state[hit_way];
    // Once the requester has released ccwait, skip WAIT and go straight home.
    assign done_state = ccwait ? WAIT : IDLE;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state     <= IDLE;
            tag_r     <= '0;
            idx_r     <= '0;
            inv_r     <= 1'b0;
            way_r     <= 1'b0;
            line_r    <= '0;
            flushed_r <= 1'b0;
        end else begin
            case (state)
                IDLE: if (ccwait) begin
                    tag_r     <= ccsnoopaddr[31:TAG_LSB];
                    idx_r     <= ccsnoopaddr[TAG_LSB-1:IDX_LSB];
                    inv_r     <= ccinv;
                    flushed_r <= 1'b0;
                    state     <= LOOKUP;
                end
                LOOKUP: begin
                    way_r  <= hit_way;
                    line_r <= snp_data[hit_way];
                    if (!hit)
                        state <= done_state;
                    else if (hit_state == M) begin
                        flushed_r <= 1'b1;
                        state     <= FLUSH0;
                    end else if (inv_r)
                        state <= INVAL;
                    else
                        state <= done_state;
                end
                FLUSH0: if (!dwait) state <= FLUSH1;
                FLUSH1: if (!dwait) state <= done_state;
                INVAL:  state <= done_state;
                WAIT:   if (!ccwait) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign flushing = (state == FLUSH0) || (state == FLUSH1);

    assign dWEN    = flushing;
    assign cctrans = flushing;
    assign daddr   = flushing ? {tag_r, idx_r, (state == FLUSH1), 2'b00} : '0;
    assign dstore  = (state == FLUSH0) ? line_r[WORD_W-1:0] :
                     (state == FLUSH1) ? line_r[LINE_W-1:WORD_W] : '0;
    assign ccwrite = (state == WAIT) && !flushed_r;

    // State write lands on the same edge the second word is accepted.
    assign snp_wen    = ((state == FLUSH1) && !dwait) || (state == INVAL);
    assign snp_way    = way_r;
    assign snp_nstate = ((state == FLUSH1) && !inv_r) ? S : I;
    assign snp_idx    = idx_r;

    assign snp_busy = (state != IDLE) || (ccwait && nRST);

endmodule

// File: doc/snoop_responder.md
SNOOP_RESPONDER -- requirements
Module: snoop_responder

Interface
REQ-001 SHALL have port CLK  in  1  system clock; all state updates on rising edge.
REQ-002 SHALL have port nRST  in  1  reset; asynchronous, active-low.
REQ-003 SHALL have port ccwait  in  1  bus controller snoop request to this cache.
REQ-004 SHALL have port ccinv  in  1  request is invalidating (initiator writes).
REQ-005 SHALL have port ccsnoopaddr  in  32  snooped byte address.
REQ-006 SHALL have port dwait  in  1  bus wait for this cache's data write; 0 = word accepted.
REQ-007 SHALL have port cctrans  out  1  cache-to-cache transfer in progress.
REQ-008 SHALL have port ccwrite  out  1  snoop complete, clean: memory supplies the data.
REQ-009 SHALL have port dWEN / daddr / dstore  out  1/32/32  write-back word to the bus.
REQ-010 SHALL have port snp_idx  out  3  array read index, driven from the captured address.
REQ-011 SHALL have port snp_tag[2] / snp_state[2] / snp_data[2]  in  26/cohstate_t/64  per-way tag, state, line.
REQ-012 SHALL have port snp_wen / snp_way / snp_nstate  out  1/1/cohstate_t  array state-write port.
REQ-013 SHALL have port snp_busy  out  1  stalls the processor-side dcache FSM.

Function
REQ-014 SHALL use address split tag[31:6], idx[5:3], blkoff[2], byte[1:0].
REQ-015 SHALL implement FSM IDLE, LOOKUP, FLUSH0, FLUSH1, INVAL, WAIT.
REQ-016 IDLE: on ccwait=1, capture ccsnoopaddr and ccinv, then go to LOOKUP next cycle.
REQ-017 LOOKUP (1 cycle): hit = tag match and state != I in either way; latch hit way and 64-bit line.
REQ-018 LOOKUP transitions: hit M -> FLUSH0; hit S and ccinv -> INVAL; hit S and !ccinv -> WAIT; miss -> WAIT.
REQ-019 FLUSH0: dWEN=1, daddr={tag,idx,0,00}, dstore=line[31:0]; go to FLUSH1 on dwait=0.
REQ-020 FLUSH1: daddr blkoff=1, dstore=line[63:32]; on dwait=0, assert snp_wen with nstate = ccinv ? I : S; then WAIT.
REQ-021 INVAL: snp_wen=1 and snp_nstate=I for exactly 1 cycle; then WAIT.
REQ-022 SHALL assert cctrans=1 in FLUSH0 and FLUSH1 only.
REQ-023 SHALL assert ccwrite=1 in WAIT only when no flush occurred.
REQ-024 WAIT: hold until ccwait=0, then IDLE; a held ccwait SHALL NOT retrigger a lookup.
REQ-025 SHALL assert snp_busy in every state except IDLE, and combinationally in IDLE when ccwait=1.
REQ-026 SHALL hold dWEN, daddr, dstore stable while dwait=1; the outputs are Moore functions of state and registers.
REQ-027 ccwait dropping in LOOKUP, FLUSH0, FLUSH1 or INVAL SHALL NOT abort: the sequence completes, then returns directly to IDLE.
REQ-028 If both ways match (illegal), SHALL use way 0.
REQ-029 Flush latency SHALL be at least 4 cycles from ccwait rise to final state write with zero-wait bus.

Reset
REQ-030 On nRST=0, SHALL enter IDLE; the captured address, ccinv, way and line registers SHALL be cleared to 0.
REQ-031 During reset, all outputs SHALL be 0 (dWEN, cctrans, ccwrite, snp_wen, snp_busy, daddr, dstore, snp_idx).
REQ-032 Reset mid-flush SHALL abandon the write-back with no array update.

Structure
REQ-033 cohstate_t (I=2'b00, S=2'b01, M=2'b10) and the tag/idx/offset width constants SHALL live in cpu_types_pkg.
REQ-034 snoop FSM state enum SHALL be local to the module.
REQ-035 SHALL have one sub-module, snoop_tag_match: a 2-way compare producing hit and way; otherwise flat.

Verification
REQ-036 Way1 tag 0x0000040 idx 2 state M, line {0xBBBB0000,0xAAAA1111}; ccwait=1, ccinv=1, addr 0x00001010, dwait=0:
  -> daddr 0x00001010 with dstore 0xAAAA1111, then 0x00001014 with dstore 0xBBBB0000; cctrans=1 both cycles; way1 set to I.
REQ-037 Same as REQ-036 with ccinv=0 -> identical write-back; way1 set to S.
REQ-038 Line S, ccinv=1 -> no dWEN, one snp_wen cycle with nstate=I, ccwrite=1 in WAIT until ccwait drops.
REQ-039 Miss (addr 0x00002010) -> no dWEN, no snp_wen, ccwrite=1, snp_busy high until ccwait=0.
REQ-040 dwait held 1 for 5 cycles in FLUSH0 -> daddr and dstore unchanged; ccwait held 10 cycles -> exactly one write-back.
REQ-041 nRST pulse in FLUSH1 -> outputs 0 immediately, IDLE, array state unchanged (M).
